// File: rtl/ulpi_phy_pkg.sv
// ulpi_phy_pkg: shared types and constants for the ULPI PHY-side responder.
//   - FSM state enum
//   - TX CMD type codes (ulpi_data_in[7:6] in IDLE)
//   - register addresses and reset values
//   - RX CMD field positions plus helpers for RX CMD, TX PID and
//     the write/set/clear register-group decode
package ulpi_phy_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD_ACK, ST_TX_DATA, ST_WR_DATA, ST_WR_STP,
    ST_RD_TA, ST_RD_DATA, ST_RX_TA, ST_RX_DATA, ST_RX_END
  } state_t;

  localparam logic [1:0] CMD_NOOP = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;

  localparam logic [5:0] ADDR_VID_LO = 6'h00;
  localparam logic [5:0] ADDR_VID_HI = 6'h01;
  localparam logic [5:0] ADDR_PID_LO = 6'h02;
  localparam logic [5:0] ADDR_PID_HI = 6'h03;
  localparam logic [5:0] ADDR_FUNC   = 6'h04;
  localparam logic [5:0] ADDR_IFC    = 6'h07;
  localparam logic [5:0] ADDR_OTG    = 6'h0A;
  localparam logic [5:0] ADDR_SCR    = 6'h16;

  localparam logic [7:0] RST_FUNC = 8'h41;
  localparam logic [7:0] RST_IFC  = 8'h00;
  localparam logic [7:0] RST_OTG  = 8'h06;
  localparam logic [7:0] RST_SCR  = 8'h00;

  localparam int RXCMD_LS_LSB   = 0;
  localparam int RXCMD_VBUS_LSB = 2;
  localparam int RXCMD_EVT_LSB  = 4;
  localparam logic [1:0] RXCMD_VBUS_VALID = 2'b11;
  localparam logic [1:0] RXEVT_ACTIVE     = 2'b01;
  localparam logic [1:0] RXEVT_NONE       = 2'b00;

  function automatic logic [7:0] rx_cmd(input logic [1:0] ls, input logic active);
    logic [7:0] b;
    b = '0;
    b[RXCMD_LS_LSB   +: 2] = ls;
    b[RXCMD_VBUS_LSB +: 2] = RXCMD_VBUS_VALID;
    b[RXCMD_EVT_LSB  +: 2] = active ? RXEVT_ACTIVE : RXEVT_NONE;
    return b;
  endfunction

  // TX CMD low nibble is the PID; USB sends it with its complement on top.
  function automatic logic [7:0] tx_pid(input logic [3:0] c);
    return {~c, c};
  endfunction

  // Each writable register occupies base (write), base+1 (set), base+2 (clear).
  function automatic logic grp_hit(input logic [5:0] a, input logic [5:0] base);
    return (a >= base) && (a <= base + 6'd2);
  endfunction

  function automatic logic [7:0] grp_upd(input logic [7:0] cur, input logic [5:0] a,
                                         input logic [5:0] base, input logic [7:0] d);
    logic [7:0] r;
    case (a - base)
      6'd0:    r = d;
      6'd1:    r = cur | d;
      default: r = cur & ~d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ulpi_phy_model_regfile.sv
// ulpi_phy_regfile: PHY register storage with write/set/clear decode and read mux.
//   i_clk, i_rst   : clock, async active-high reset (registers to reset values)
//   i_we           : commit strobe for i_waddr/i_wdata
//   i_raddr        : read address, o_rdata combinational read data
// Unmapped addresses (including the extended-address escape 0x2F) read 0x00
// and silently drop writes.
module ulpi_phy_regfile
  import ulpi_phy_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0451,
  parameter logic [15:0] PRODUCT_ID = 16'h1507
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [5:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_func, r_ifc, r_otg, r_scr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_func <= RST_FUNC;
      r_ifc  <= RST_IFC;
      r_otg  <= RST_OTG;
      r_scr  <= RST_SCR;
    end else if (i_we) begin
      if (grp_hit(i_waddr, ADDR_FUNC)) r_func <= grp_upd(r_func, i_waddr, ADDR_FUNC, i_wdata);
      if (grp_hit(i_waddr, ADDR_IFC))  r_ifc  <= grp_upd(r_ifc,  i_waddr, ADDR_IFC,  i_wdata);
      if (grp_hit(i_waddr, ADDR_OTG))  r_otg  <= grp_upd(r_otg,  i_waddr, ADDR_OTG,  i_wdata);
      if (grp_hit(i_waddr, ADDR_SCR))  r_scr  <= grp_upd(r_scr,  i_waddr, ADDR_SCR,  i_wdata);
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    if      (i_raddr == ADDR_VID_LO)      o_rdata = VENDOR_ID[7:0];
    else if (i_raddr == ADDR_VID_HI)      o_rdata = VENDOR_ID[15:8];
    else if (i_raddr == ADDR_PID_LO)      o_rdata = PRODUCT_ID[7:0];
    else if (i_raddr == ADDR_PID_HI)      o_rdata = PRODUCT_ID[15:8];
    else if (grp_hit(i_raddr, ADDR_FUNC)) o_rdata = r_func;
    else if (grp_hit(i_raddr, ADDR_IFC))  o_rdata = r_ifc;
    else if (grp_hit(i_raddr, ADDR_OTG))  o_rdata = r_otg;
    else if (grp_hit(i_raddr, ADDR_SCR))  o_rdata = r_scr;
  end

endmodule

// File: rtl/ulpi_phy_model.sv
// ulpi_phy_model: PHY end of a ULPI bus. Answers link TX CMDs (USB transmit,
// register write, register read) and injects RX packets toward the link.
//   clk_i, rst_i                  : 60 MHz ULPI clock, async active-high reset
//   ulpi_data_in_i / ulpi_stp_i   : link-driven bus byte and stop
//   ulpi_data_out_o, ulpi_dir_o,
//   ulpi_nxt_o                    : PHY-driven bus (registered)
//   tx_data/valid/last/abort_o    : USB bytes sent by the link (registered strobes)
//   tx_hold_i                     : throttles nxt during TX data
//   rx_data/valid/last_i          : packet bytes to deliver; rx_ready_o marks the
//                                   cycle a consumed byte is on the bus
// All bus outputs are registered from the next state, so they line up with the
// state they describe. An RX byte is sampled in each RX_TA/RX_DATA cycle that
// has rx_valid_i and shows up on the bus (with nxt, rx_ready_o) the cycle after.
module ulpi_phy_model
  import ulpi_phy_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0451,
  parameter logic [15:0] PRODUCT_ID = 16'h1507,
  parameter logic [1:0]  LINESTATE  = 2'b01
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_in_i,
  output logic [7:0] ulpi_data_out_o,
  output logic       ulpi_dir_o,
  output logic       ulpi_nxt_o,
  input  logic       ulpi_stp_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       tx_last_o,
  output logic       tx_abort_o,
  input  logic       tx_hold_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_last_i,
  output logic       rx_ready_o
);

  state_t     r_state, w_state_n;
  logic [7:0] r_cmd, r_wdata, r_hold;
  logic       r_ta, r_rx_last;
  logic       r_dir, r_nxt, r_tx_valid, r_tx_last, r_tx_abort, r_rx_ready;
  logic [7:0] r_dout, r_tx_data;
  logic       w_dir_n, w_nxt_n;
  logic [7:0] w_dout_n, w_rdata;
  logic       w_cmd_seen, w_rx_take, w_tx_end, w_tx_fire, w_we;

  // r_ta blanks the first IDLE cycle after dir falls (bus turnaround).
  assign w_cmd_seen = (r_state == ST_IDLE) && !r_ta && (ulpi_data_in_i[7:6] != CMD_NOOP);
  assign w_rx_take  = ((r_state == ST_RX_TA) || ((r_state == ST_RX_DATA) && !r_rx_last))
                      && rx_valid_i;
  assign w_tx_end   = (r_state == ST_TX_DATA) && ulpi_stp_i;
  assign w_tx_fire  = (r_state == ST_TX_DATA) && (ulpi_stp_i || r_nxt);
  assign w_we       = (r_state == ST_WR_STP) && ulpi_stp_i;

  ulpi_phy_regfile #(.VENDOR_ID(VENDOR_ID), .PRODUCT_ID(PRODUCT_ID)) u_regfile (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_we),
    .i_waddr (r_cmd[5:0]),
    .i_wdata (r_wdata),
    .i_raddr (r_cmd[5:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        // A link command beats a same-cycle RX request.
        if (w_cmd_seen)                  w_state_n = ST_CMD_ACK;
        else if (!r_ta && rx_valid_i)    w_state_n = ST_RX_TA;
      end
      ST_CMD_ACK: begin
        case (r_cmd[7:6])
          CMD_TX:   w_state_n = ST_TX_DATA;
          CMD_REGW: w_state_n = ST_WR_DATA;
          CMD_REGR: w_state_n = ST_RD_TA;
          default:  w_state_n = ST_IDLE;
        endcase
      end
      ST_TX_DATA: if (ulpi_stp_i) w_state_n = ST_IDLE;
      ST_WR_DATA: w_state_n = ST_WR_STP;
      ST_WR_STP:  if (ulpi_stp_i) w_state_n = ST_IDLE;
      ST_RD_TA:   w_state_n = ST_RD_DATA;
      ST_RD_DATA: w_state_n = ST_IDLE;
      ST_RX_TA:   w_state_n = ST_RX_DATA;
      ST_RX_DATA: if (r_rx_last) w_state_n = ST_RX_END;
      ST_RX_END:  w_state_n = ST_IDLE;
      default:    w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dir_n  = 1'b0;
    w_nxt_n  = 1'b0;
    w_dout_n = 8'h00;
    case (w_state_n)
      ST_CMD_ACK, ST_WR_DATA: w_nxt_n = 1'b1;
      ST_TX_DATA: w_nxt_n = ~tx_hold_i;
      ST_RD_TA:   w_dir_n = 1'b1;
      ST_RD_DATA: begin
        w_dir_n  = 1'b1;
        w_dout_n = w_rdata;
      end
      ST_RX_TA: begin
        w_dir_n = 1'b1;
        w_nxt_n = 1'b1;
      end
      ST_RX_DATA: begin
        w_dir_n  = 1'b1;
        w_nxt_n  = w_rx_take;
        w_dout_n = w_rx_take ? rx_data_i : rx_cmd(LINESTATE, 1'b1);
      end
      ST_RX_END: begin
        w_dir_n  = 1'b1;
        w_dout_n = rx_cmd(LINESTATE, 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_wdata    <= '0;
      r_hold     <= '0;
      r_ta       <= 1'b0;
      r_rx_last  <= 1'b0;
      r_dir      <= 1'b0;
      r_nxt      <= 1'b0;
      r_dout     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_tx_abort <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_dir      <= w_dir_n;
      r_nxt      <= w_nxt_n;
      r_dout     <= w_dout_n;
      r_ta       <= (r_state == ST_RD_DATA) || (r_state == ST_RX_END);
      r_rx_ready <= w_rx_take;
      r_rx_last  <= w_rx_take && rx_last_i;
      if (w_cmd_seen)              r_cmd   <= ulpi_data_in_i;
      if (r_state == ST_WR_DATA)   r_wdata <= ulpi_data_in_i;
      // One-byte hold delays TX data so the byte on the stp cycle can be
      // flagged as last without knowing ahead of time.
      if (r_state == ST_CMD_ACK)   r_hold  <= tx_pid(r_cmd[3:0]);
      else if ((r_state == ST_TX_DATA) && r_nxt && !ulpi_stp_i)
                                   r_hold  <= ulpi_data_in_i;
      r_tx_valid <= w_tx_fire;
      if (w_tx_fire)               r_tx_data <= r_hold;
      r_tx_last  <= w_tx_end;
      r_tx_abort <= w_tx_end && (ulpi_data_in_i == 8'hFF);
    end
  end

  assign ulpi_data_out_o = r_dout;
  assign ulpi_dir_o      = r_dir;
  assign ulpi_nxt_o      = r_nxt;
  assign tx_data_o       = r_tx_data;
  assign tx_valid_o      = r_tx_valid;
  assign tx_last_o       = r_tx_last;
  assign tx_abort_o      = r_tx_abort;
  assign rx_ready_o      = r_rx_ready;

endmodule
